// File: rtl/bp_fe_btb_update_queue_if.sv
// Update-side and BTB-write-side signals of the BTB update queue.
// The queue is the slave and its environment (back end plus BTB) is the master.
interface bp_fe_btb_update_queue_if #(
  parameter int eaddr_width_p   = 64,
  parameter int btb_idx_width_p = 9
);
  logic                       update_v_i;
  logic                       update_ready_o;
  logic [eaddr_width_p-1:0]   update_pc_i;
  logic [eaddr_width_p-1:0]   update_target_i;
  logic                       btb_r_v_i;
  logic [btb_idx_width_p-1:0] btb_idx_r_i;
  logic                       btb_w_v_o;
  logic [btb_idx_width_p-1:0] btb_idx_w_o;
  logic [eaddr_width_p-1:0]   btb_target_o;

  modport master (
    output update_v_i, update_pc_i, update_target_i, btb_r_v_i, btb_idx_r_i,
    input  update_ready_o, btb_w_v_o, btb_idx_w_o, btb_target_o
  );

  modport slave (
    input  update_v_i, update_pc_i, update_target_i, btb_r_v_i, btb_idx_r_i,
    output update_ready_o, btb_w_v_o, btb_idx_w_o, btb_target_o
  );
endinterface

// File: rtl/bp_fe_btb_update_queue.sv
// Small FIFO of resolved-branch updates in front of the BTB write port: one write per cycle,
// same-index coalescing at the tail, bounded deferral when the BTB reads the head index.
module bp_fe_btb_update_queue #(
  parameter int eaddr_width_p   = 64,
  parameter int btb_idx_width_p = 9,
  parameter int els_p           = 4,
  parameter int max_defer_p     = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  bp_fe_btb_update_queue_if.slave      bus,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);
  localparam int def_w = (max_defer_p < 1) ? 1 : $clog2(max_defer_p+1);

  localparam logic [cnt_w-1:0] els_c     = cnt_w'(els_p);
  localparam logic [cnt_w-1:0] one_c     = cnt_w'(1);
  localparam logic [def_w-1:0] max_def_c = def_w'(max_defer_p);

  logic [btb_idx_width_p-1:0] idx_mem_q [els_p];
  logic [eaddr_width_p-1:0]   tgt_mem_q [els_p];

  logic [ptr_w-1:0] head_q, head_d;
  logic [ptr_w-1:0] tail_q, tail_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic [def_w-1:0] defer_cnt_q, defer_cnt_d;

  logic [ptr_w-1:0]           tail_last;
  logic [btb_idx_width_p-1:0] in_idx;
  logic [btb_idx_width_p-1:0] head_idx;
  logic                       not_empty;
  logic                       ready;
  logic                       defer;
  logic                       w_v;
  logic                       accept;
  logic                       coalesce;
  logic                       enq;

  // tail_q points at the next free slot; the most recent entry sits one behind it
  assign tail_last = tail_q - ptr_w'(1);
  assign in_idx    = bus.update_pc_i[btb_idx_width_p+1:2];
  assign head_idx  = idx_mem_q[head_q];
  assign not_empty = (count_q != '0);
  assign ready     = (count_q < els_c);

  assign defer = bus.btb_r_v_i && (bus.btb_idx_r_i == head_idx) && (defer_cnt_q < max_def_c);
  assign w_v   = not_empty && !flush_i && !defer;

  assign accept = bus.update_v_i && ready && !flush_i;

  // Never merge into an entry that is leaving through the write port this cycle
  assign coalesce = accept && not_empty
                 && (in_idx == idx_mem_q[tail_last])
                 && !((count_q == one_c) && w_v);
  assign enq = accept && !coalesce;

  assign bus.update_ready_o = ready;
  assign bus.btb_w_v_o      = w_v;
  assign bus.btb_idx_w_o    = head_idx;
  assign bus.btb_target_o   = tgt_mem_q[head_q];
  assign count_o            = count_q;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    defer_cnt_d = defer_cnt_q;
    if (flush_i) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      defer_cnt_d = '0;
    end else begin
      if (w_v) head_d = head_q + ptr_w'(1);
      if (enq) tail_d = tail_q + ptr_w'(1);
      unique case ({enq, w_v})
        2'b10:   count_d = count_q + one_c;
        2'b01:   count_d = count_q - one_c;
        default: count_d = count_q;
      endcase
      if (w_v) begin
        defer_cnt_d = '0;
      end else if (not_empty && defer) begin
        defer_cnt_d = defer_cnt_q + def_w'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      defer_cnt_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      defer_cnt_q <= defer_cnt_d;
    end
  end

  // Storage holds no reset value; occupancy alone decides what is meaningful
  always_ff @(posedge clk_i) begin
    if (enq) begin
      idx_mem_q[tail_q] <= in_idx;
      tgt_mem_q[tail_q] <= bus.update_target_i;
    end
    if (coalesce) begin
      tgt_mem_q[tail_last] <= bus.update_target_i;
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   accept |-> (count_q < els_c));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    w_v |-> not_empty);

endmodule
